// File: rtl/dsp_ctr_seq_if.sv
// Instruction, counter-control and status bundle between the TPU control
// logic (master) and the dsp_ctr sequencer (slave).
interface dsp_ctr_seq_if #(
    parameter int COUNTER_WIDTH = 6,
    parameter int REP_WIDTH     = 8
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [COUNTER_WIDTH-1:0] instr_len;
    logic [REP_WIDTH-1:0]     instr_reps;
    logic                     abort;
    logic                     ctr_enable;
    logic                     ctr_load;
    logic [COUNTER_WIDTH-1:0] ctr_end_val;
    logic                     ctr_event;
    logic                     pass_done;
    logic [REP_WIDTH-1:0]     pass_idx;
    logic                     done;
    logic                     busy;

    modport master (
        output instr_valid, instr_len, instr_reps, abort, ctr_event,
        input  instr_ready, ctr_enable, ctr_load, ctr_end_val,
               pass_done, pass_idx, done, busy
    );

    modport slave (
        input  instr_valid, instr_len, instr_reps, abort, ctr_event,
        output instr_ready, ctr_enable, ctr_load, ctr_end_val,
               pass_done, pass_idx, done, busy
    );
endinterface

// File: rtl/dsp_ctr_seq.sv
// Sequencer that runs a dsp_ctr through a number of passes of a given length,
// reloading between passes and reporting per-pass and final completion.
module dsp_ctr_seq #(
    parameter int COUNTER_WIDTH = 6,
    parameter int REP_WIDTH     = 8
) (
    input  logic          clk,
    input  logic          rst,
    dsp_ctr_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [COUNTER_WIDTH-1:0] len_reg;
    logic [REP_WIDTH-1:0]     reps_reg;
    logic [REP_WIDTH-1:0]     pass_cnt_reg;
    logic [REP_WIDTH-1:0]     pass_idx_reg;
    logic                     pass_done_reg;

    logic                     accept;
    logic                     pass_event;
    logic                     last_pass;
    logic [REP_WIDTH:0]       pass_cnt_inc;

    assign bus.instr_ready = (state_reg == IDLE) && !bus.abort;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // One extra bit so that reps=2^REP_WIDTH-1 compares without wrapping.
    assign pass_cnt_inc = {1'b0, pass_cnt_reg} + (REP_WIDTH+1)'(1);
    assign last_pass    = (pass_cnt_inc == {1'b0, reps_reg});

    // A counter event only counts while running and not being cancelled.
    assign pass_event = (state_reg == RUN) && bus.ctr_event && !bus.abort;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if ((bus.instr_len == '0) || (bus.instr_reps == '0))
                        state_next = DONE;
                    else
                        state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = bus.abort ? IDLE : RUN;
            end
            RUN: begin
                if (bus.abort)
                    state_next = IDLE;
                else if (bus.ctr_event)
                    state_next = last_pass ? DONE : LOAD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg       <= '0;
            reps_reg      <= '0;
            pass_cnt_reg  <= '0;
            pass_idx_reg  <= '0;
            pass_done_reg <= 1'b0;
        end else begin
            pass_done_reg <= pass_event;
            if (accept) begin
                len_reg      <= bus.instr_len;
                reps_reg     <= bus.instr_reps;
                pass_cnt_reg <= '0;
            end else if (pass_event) begin
                pass_idx_reg <= pass_cnt_reg;
                pass_cnt_reg <= pass_cnt_inc[REP_WIDTH-1:0];
            end
        end
    end

    // Control and status are straight decodes of the registered state.
    assign bus.ctr_enable  = (state_reg == LOAD) || (state_reg == RUN);
    assign bus.ctr_load    = (state_reg == LOAD);
    assign bus.ctr_end_val = len_reg;
    assign bus.pass_done   = pass_done_reg;
    assign bus.pass_idx    = pass_idx_reg;
    assign bus.done        = (state_reg == DONE);
    assign bus.busy        = (state_reg != IDLE);

endmodule
